// File: rtl/frame_streamer_pkg.sv
// Shared types and helpers for the frame streamer.
//   clog2     : constant-foldable ceiling log2, used for port/counter widths
//   state_t   : streamer FSM states
//   pixel_t   : one RAM word = CH_NUM channels of DIN_WIDTH bits
package frame_streamer_pkg;

   localparam int DIN_WIDTH = 8;
   localparam int CH_NUM    = 4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) result = result + 1;
      return result;
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      GAP,
      FLUSH,
      DONE
   } state_t;

   typedef logic [CH_NUM-1:0][DIN_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/frame_streamer_if.sv
// Frame-buffer read port plus the pixel stream towards the convolution datapath.
//   mem_rd_en / mem_rd_addr : read request, data returns one cycle later
//   mem_rd_data             : registered RAM output
//   frame_start / din_vld / din : pixel stream, no backpressure
// master = streamer, slave = RAM + datapath side.
interface frame_streamer_if #(
   parameter int ADDR_WIDTH = 16
) ();
   import frame_streamer_pkg::*;

   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   pixel_t                mem_rd_data;
   logic                  frame_start;
   logic                  din_vld;
   pixel_t                din;

   modport master (
      output mem_rd_en,
      output mem_rd_addr,
      input  mem_rd_data,
      output frame_start,
      output din_vld,
      output din
   );

   modport slave (
      input  mem_rd_en,
      input  mem_rd_addr,
      output mem_rd_data,
      input  frame_start,
      input  din_vld,
      input  din
   );
endinterface

// File: rtl/frame_addr_gen.sv
// Raster scan counters for the frame streamer.
//   clear     : restart at pixel (0,0), address 0
//   advance   : one pixel read issued this cycle, step to the next pixel
//   frame_h/w : latched, already clamped frame dimensions
//   addr      : linear word address y*frame_w + x, kept as a running count
//   row_end   : current pixel is the last of its row
//   frame_end : current pixel is the last of the frame
module frame_addr_gen #(
   parameter int H_WIDTH    = 9,
   parameter int W_WIDTH    = 9,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  advance,
   input  logic [H_WIDTH-1:0]    frame_h,
   input  logic [W_WIDTH-1:0]    frame_w,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  row_end,
   output logic                  frame_end
);

   logic [W_WIDTH-1:0] x;
   logic [H_WIDTH-1:0] y;

   assign row_end   = (x == frame_w - W_WIDTH'(1));
   assign frame_end = row_end && (y == frame_h - H_WIDTH'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (advance) begin
         addr <= addr + ADDR_WIDTH'(1);
         if (row_end) begin
            x <= '0;
            y <= y + H_WIDTH'(1);
         end else begin
            x <= x + W_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/frame_streamer.sv
// Streams one frame from the frame-buffer RAM into the convolution datapath.
//   clk, reset_n     : clock, async active-low reset
//   frame_h, frame_w : frame size, sampled when start is accepted (clamped to MAX)
//   start/busy/done  : sequencer handshake
//   hold             : pauses new RAM reads (reads in flight still emit)
//   strm             : RAM read port and pixel stream (master side)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one RAM read per cycle unless hold is high
// GAP   | ROW_GAP idle cycles between rows for the row-buffer rotation
// FLUSH | last read data returning from RAM
// DONE  | one-cycle done pulse, busy already low
module frame_streamer
   import frame_streamer_pkg::*;
#(
   parameter int FRAME_H_MAX = 224,
   parameter int FRAME_W_MAX = 224,
   parameter int ROW_GAP     = 2,
   parameter int ADDR_WIDTH  = clog2(FRAME_H_MAX * FRAME_W_MAX),
   localparam int H_WIDTH    = clog2(FRAME_H_MAX) + 1,
   localparam int W_WIDTH    = clog2(FRAME_W_MAX) + 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [H_WIDTH-1:0] frame_h,
   input  logic [W_WIDTH-1:0] frame_w,
   input  logic               start,
   input  logic               hold,
   output logic               busy,
   output logic               done,
   frame_streamer_if.master   strm
);

   localparam int GAP_W = clog2(ROW_GAP + 2);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
   localparam bit HAS_GAP = (ROW_GAP > 0);

   state_t                 state;
   logic [H_WIDTH-1:0]     fh_q;
   logic [W_WIDTH-1:0]     fw_q;
   logic [GAP_W-1:0]       gap_cnt;
   logic                   first_pend;
   logic                   din_vld_q;
   logic                   frame_start_q;

   logic [H_WIDTH-1:0]     h_clamped;
   logic [W_WIDTH-1:0]     w_clamped;
   logic                   accept;
   logic                   dim_zero;
   logic                   rd_en;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic                   row_end;
   logic                   frame_end;

   assign h_clamped = (frame_h > H_WIDTH'(FRAME_H_MAX)) ? H_WIDTH'(FRAME_H_MAX) : frame_h;
   assign w_clamped = (frame_w > W_WIDTH'(FRAME_W_MAX)) ? W_WIDTH'(FRAME_W_MAX) : frame_w;

   assign accept   = (state == IDLE) && start;
   assign dim_zero = (fh_q == '0) || (fw_q == '0);
   // Read strobe follows hold in the same cycle so a paused cycle never issues a read.
   assign rd_en    = (state == RUN) && !hold && !dim_zero;

   frame_addr_gen #(
      .H_WIDTH    (H_WIDTH),
      .W_WIDTH    (W_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (accept),
      .advance   (rd_en),
      .frame_h   (fh_q),
      .frame_w   (fw_q),
      .addr      (rd_addr),
      .row_end   (row_end),
      .frame_end (frame_end)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         fh_q    <= '0;
         fw_q    <= '0;
         gap_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  fh_q  <= h_clamped;
                  fw_q  <= w_clamped;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (dim_zero) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (!hold && frame_end) begin
                  state <= FLUSH;
               end else if (!hold && row_end && HAS_GAP) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= RUN;
               else               gap_cnt <= gap_cnt - GAP_W'(1);
            end
            FLUSH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Pixel stream: valid trails the read strobe by the RAM's one-cycle latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_vld_q     <= 1'b0;
         frame_start_q <= 1'b0;
         first_pend    <= 1'b0;
      end else begin
         din_vld_q     <= rd_en;
         frame_start_q <= rd_en && first_pend;
         if (accept)     first_pend <= 1'b1;
         else if (rd_en) first_pend <= 1'b0;
      end
   end

   assign strm.mem_rd_en   = rd_en;
   assign strm.mem_rd_addr = rd_addr;
   assign strm.din_vld     = din_vld_q;
   assign strm.frame_start = frame_start_q;
   assign strm.din         = strm.mem_rd_data;

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer: table of directed frames, hand-written
// multi-cycle sequences, and randomized frames against a raster-order model.
module tb_frame_streamer;
   import frame_streamer_pkg::*;

   localparam int G  = 2;
   localparam int AW = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [8:0] frame_h = '0;
   logic [8:0] frame_w = '0;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic       busy;
   logic       done;

   frame_streamer_if #(.ADDR_WIDTH(AW)) bus ();

   frame_streamer #(
      .FRAME_H_MAX (224),
      .FRAME_W_MAX (224),
      .ROW_GAP     (G)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .frame_h (frame_h),
      .frame_w (frame_w),
      .start   (start),
      .hold    (hold),
      .busy    (busy),
      .done    (done),
      .strm    (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int c0  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit use_hash = 1'b0;
   function automatic logic [31:0] ram_word(input int a);
      if (use_hash) return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      return 32'(a);
   endfunction

   always @(posedge clk)
      if (bus.mem_rd_en) bus.mem_rd_data <= pixel_t'(ram_word(int'(bus.mem_rd_addr)));

   typedef struct {
      int          cyc;
      logic [31:0] data;
      bit          fs;
   } pix_rec_t;

   pix_rec_t pix_q[$];
   int       done_q[$];
   int       addr_q[$];
   int       busy_cnt = 0;

   initial forever begin
      @(negedge clk);
      #2;
      if (bus.din_vld) pix_q.push_back('{cyc - c0, 32'(bus.din), bus.frame_start});
      if (done) done_q.push_back(cyc - c0);
      if (bus.mem_rd_en) addr_q.push_back(int'(bus.mem_rd_addr));
      if (busy) busy_cnt++;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_log();
      pix_q.delete();
      done_q.delete();
      addr_q.delete();
      busy_cnt = 0;
   endtask

   task automatic do_frame(input int h, input int w, input int hf, input int ht,
                           input int hold_pct, input int budget);
      clear_log();
      @(negedge clk);
      c0      = cyc;
      frame_h = 9'(h);
      frame_w = 9'(w);
      start   = 1'b1;
      hold    = (hf <= 0 && ht >= 0);
      for (int r = 1; r < budget && done_q.size() == 0; r++) begin
         @(negedge clk);
         start = 1'b0;
         hold  = (r >= hf && r <= ht) ||
                 (hold_pct > 0 && int'($urandom_range(99)) < hold_pct);
      end
      start = 1'b0;
      hold  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Reference: pixels leave in raster order, one word per address; without hold,
   // pixel (r,c) is valid at 2 + r*(w+G) + c and done follows the last pixel.
   task automatic check_frame(input string tag, input int h, input int w,
                              input bit exact, input int exp_done);
      int n, bad, fs_cnt;
      n = h * w;
      chk({tag, ".done_seen"}, done_q.size(), 1);
      chk({tag, ".pix_cnt"}, pix_q.size(), n);
      bad = 0;
      fs_cnt = 0;
      for (int k = 0; k < pix_q.size(); k++) begin
         if (k >= n || pix_q[k].data != ram_word(k)) bad++;
         if (pix_q[k].fs) fs_cnt++;
      end
      chk({tag, ".pix_data"}, bad, 0);
      chk({tag, ".fs_cnt"}, fs_cnt, (n > 0) ? 1 : 0);
      if (pix_q.size() > 0) chk({tag, ".fs_first"}, pix_q[0].fs, 1);
      if (done_q.size() > 0) begin
         if (pix_q.size() > 0) chk({tag, ".done_after_last"}, done_q[0], pix_q[pix_q.size()-1].cyc + 1);
         else                  chk({tag, ".done_zero"}, done_q[0], 2);
         chk({tag, ".busy_cycles"}, busy_cnt, done_q[0] - 1);
         if (exp_done >= 0) chk({tag, ".done_cycle"}, done_q[0], exp_done);
      end
      if (w > 0 && pix_q.size() > 0) begin
         bad = 0;
         for (int k = 1; k < pix_q.size(); k++)
            if (k % w == 0 && pix_q[k].cyc - pix_q[k-1].cyc < G + 1) bad++;
         chk({tag, ".row_gap"}, bad, 0);
         if (exact) begin
            bad = 0;
            for (int k = 0; k < pix_q.size(); k++)
               if (pix_q[k].cyc != 2 + (k / w) * (w + G) + (k % w)) bad++;
            chk({tag, ".vld_timing"}, bad, 0);
         end
      end
   endtask

   typedef struct {
      int h;
      int w;
      int hf;
      int ht;
      int exp_n;
      int exp_first;
      int exp_done;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{3, 4, -1, -1, 12, 2, 18};
      vecs[1] = '{3, 4,  3,  5, 12, 2, 21};
      vecs[2] = '{0, 4, -1, -1,  0, -1, 2};
      vecs[3] = '{3, 0, -1, -1,  0, -1, 2};
      vecs[4] = '{1, 1, -1, -1,  1, 2, 3};
      vecs[5] = '{1, 5, -1, -1,  5, 2, 7};
      vecs[6] = '{4, 1, -1, -1,  4, 2, 12};
      vecs[7] = '{2, 2,  0,  2,  4, 4, 10};

      #12;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.rd_en", bus.mem_rd_en, 0);
      chk("rst.rd_addr", bus.mem_rd_addr, 0);
      chk("rst.din_vld", bus.din_vld, 0);
      chk("rst.frame_start", bus.frame_start, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         do_frame(vecs[i].h, vecs[i].w, vecs[i].hf, vecs[i].ht, 0, 200);
         chk({tag, ".exp_n"}, pix_q.size(), vecs[i].exp_n);
         if (vecs[i].exp_n > 0 && pix_q.size() > 0)
            chk({tag, ".first_vld"}, pix_q[0].cyc, vecs[i].exp_first);
         check_frame(tag, vecs[i].h, vecs[i].w, vecs[i].hf < 0, vecs[i].exp_done);
      end

      // Starts while busy (mid-frame and in the DONE cycle) are ignored;
      // a start right after DONE begins a fresh 2x2 frame.
      begin
         int bad;
         clear_log();
         @(negedge clk);
         c0 = cyc;
         frame_h = 9'd3;
         frame_w = 9'd4;
         start = 1'b1;
         for (int r = 1; r < 40; r++) begin
            @(negedge clk);
            start = (r == 6 || r == 18 || r == 19);
            if (r == 19) begin
               frame_h = 9'd2;
               frame_w = 9'd2;
            end else if (start) begin
               frame_h = 9'd1;
               frame_w = 9'd1;
            end
         end
         start = 1'b0;
         chk("busy_start.done_cnt", done_q.size(), 2);
         if (done_q.size() >= 2) begin
            chk("busy_start.done0", done_q[0], 18);
            chk("busy_start.done1", done_q[1], 27);
         end
         chk("busy_start.pix_cnt", pix_q.size(), 16);
         bad = 0;
         for (int k = 0; k < pix_q.size(); k++)
            if (pix_q[k].data != 32'((k < 12) ? k : k - 12)) bad++;
         chk("busy_start.pix_data", bad, 0);
         bad = 0;
         for (int k = 0; k < pix_q.size(); k++)
            if (pix_q[k].fs != (k == 0 || k == 12)) bad++;
         chk("busy_start.fs", bad, 0);
      end

      // Asynchronous reset at the fifth pixel of a full-size frame.
      begin
         clear_log();
         @(negedge clk);
         c0 = cyc;
         frame_h = 9'd224;
         frame_w = 9'd224;
         start = 1'b1;
         for (int r = 1; r <= 6; r++) begin
            @(negedge clk);
            start = 1'b0;
         end
         #3;
         chk("midrst.pixels_before", pix_q.size(), 5);
         chk("midrst.rd_en_before", bus.mem_rd_en, 1);
         reset_n = 1'b0;
         #1;
         chk("midrst.busy", busy, 0);
         chk("midrst.done", done, 0);
         chk("midrst.rd_en", bus.mem_rd_en, 0);
         chk("midrst.rd_addr", bus.mem_rd_addr, 0);
         chk("midrst.din_vld", bus.din_vld, 0);
         chk("midrst.frame_start", bus.frame_start, 0);
         @(negedge clk);
         reset_n = 1'b1;
         repeat (3) @(negedge clk);
         chk("midrst.no_done", done_q.size(), 0);
         do_frame(2, 2, -1, -1, 0, 100);
         check_frame("midrst_restart", 2, 2, 1'b1, 8);
      end

      // Over-wide frame clamps to 224 with contiguous addresses.
      begin
         int bad;
         do_frame(2, 300, -1, -1, 0, 1000);
         check_frame("clamp", 2, 224, 1'b1, 2 + 448 + G);
         chk("clamp.addr_cnt", addr_q.size(), 448);
         bad = 0;
         for (int k = 0; k < addr_q.size(); k++)
            if (addr_q[k] != k) bad++;
         chk("clamp.addr_seq", bad, 0);
      end

      use_hash = 1'b1;
      for (int i = 0; i < 20; i++) begin
         int h, w, hp, n;
         h  = int'($urandom_range(0, 6));
         w  = int'($urandom_range(0, 7));
         hp = ($urandom_range(0, 1) == 1) ? 30 : 0;
         n  = h * w;
         do_frame(h, w, -1, -1, hp, 400);
         check_frame($sformatf("rnd%0d_%0dx%0d", i, h, w), h, w, hp == 0,
                     (hp != 0) ? -1 : ((n == 0) ? 2 : 2 + n + (h - 1) * G));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Transmit side of the convolution pixel-stream interface (frame_start / din_vld / din).
- Reads one frame, row-major with channels packed per word, from a synchronous frame-buffer RAM.
- Drives the frame into the convolution datapath, which has no backpressure.
- Started by a start/busy/done handshake from the layer sequencer; inserts a programmable idle gap between rows so the downstream row buffer can rotate lines.

Parameters:
- FRAME_H_MAX, 224: maximum frame height in pixels.
- FRAME_W_MAX, 224: maximum frame width in pixels.
- DIN_WIDTH, 8: bits per channel sample.
- CH_NUM, 4: channels packed in one pixel word.
- ROW_GAP, 2: idle cycles inserted after each row except the last (0 allowed).
- ADDR_WIDTH, clog2(FRAME_H_MAX*FRAME_W_MAX): RAM word address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- frame_h  in  clog2(FRAME_H_MAX)+1  frame height, sampled on accepted start
- frame_w  in  clog2(FRAME_W_MAX)+1  frame width, sampled on accepted start
- start  in  1  one-cycle request to stream a frame
- hold  in  1  pause; no new RAM reads are issued while high
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, frame fully emitted
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  ADDR_WIDTH  RAM word address
- mem_rd_data  in  CH_NUM*DIN_WIDTH  RAM data, valid 1 cycle after mem_rd_en
- frame_start  out  1  marks the first pixel of the frame, coincident with its din_vld
- din_vld  out  1  pixel valid
- din  out  [CH_NUM-1:0][DIN_WIDTH-1:0]  pixel data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values: busy, done, mem_rd_en, frame_start and din_vld are 0. mem_rd_addr is 0. The FSM is IDLE.
- Reset mid-frame: all outputs drop to their reset values immediately. No done pulse is produced. The next start restarts from address 0.
- FSM states: IDLE, RUN, GAP, FLUSH, DONE.
- IDLE:
  - start=1 latches frame_h and frame_w. Values above the MAX parameter clamp to that MAX.
  - Clears the x/y counters and the address counter, sets busy, goes to RUN.
  - If either latched dimension is 0: go to DONE directly, with no read and no din_vld.
- RUN, per cycle with hold=0:
  - Assert mem_rd_en with mem_rd_addr = y*frame_w + x. This is kept as an incrementing counter, with no multiplier.
  - Then advance x. At x = frame_w-1: wrap x to 0 and advance y.
  - After the last pixel of a row: go to GAP if ROW_GAP>0 and the row was not the last, else stay in RUN.
  - After the last pixel of the frame: go to FLUSH.
- RUN with hold=1: mem_rd_en=0 and all counters are frozen. hold has no effect on a read already issued.
- GAP: counts ROW_GAP cycles with mem_rd_en=0, then returns to RUN. hold is ignored in GAP; the gap is not extended.
- FLUSH: waits one cycle for the last read data, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, next state IDLE.
- Output path:
  - din_vld is mem_rd_en delayed by one register stage.
  - din = mem_rd_data unregistered; the RAM output is registered.
  - frame_start=1 only together with the first din_vld of the frame.
- Latency (hold=0): start accepted at cycle 0, first mem_rd_en at cycle 1, first din_vld and frame_start at cycle 2.
- Frame length: frame_h*frame_w pixels plus (frame_h-1)*ROW_GAP gap cycles. done rises one cycle after the last din_vld.
- Simultaneous events:
  - start while busy is ignored, including in the DONE cycle.
  - hold and start arriving together in IDLE: start is accepted and the first read waits for hold=0.
- Frame sizes 1x1, 1xW and Hx1 are legal. With frame_w=1, every row except the last is followed by a gap.

Decomposition:
- functions_pkg provides clog2 (existing).
- Add to conv_pkg: the FSM state enum (IDLE, RUN, GAP, FLUSH, DONE) and the pixel word typedef logic [CH_NUM-1:0][DIN_WIDTH-1:0].
- One natural sub-module, frame_addr_gen: the x/y counters, row-end/frame-end flags and the linear address counter.
- The FSM and output stage stay in the top level.

Test Plan:
- 4x3 frame, ROW_GAP=2, hold=0, RAM word n = n -> din values 0..11 in order; frame_start only with pixel 0; 2 idle cycles after pixels 3 and 7; first din_vld at cycle 2 after start; done at cycle 18.
- Same frame with hold high on cycles 3-5 -> still 12 pixels with no loss or duplication; the read in flight at cycle 2 still emits; done shifts later by exactly 3 cycles.
- frame_h=0 or frame_w=0 -> no mem_rd_en and no din_vld; done pulses 2 cycles after start; busy high for one cycle.
- Second start pulsed mid-frame and again in the DONE cycle -> both ignored; a single frame is emitted; a start one cycle after done is accepted normally.
- reset_n low at the 5th pixel of a 224x224 frame -> outputs 0 asynchronously; restarting with 2x2 yields pixels 0..3 and one done.
- frame_w=300 with FRAME_W_MAX=224 -> clamped to 224; addresses run 0..224*frame_h-1 with no gaps.
